// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, float class codes and the exponent bias helper.
// Consumers: fp_round_decide and fp_to_int_pipe (macro FP_TO_INT_RMODE_EN selects rm support there).
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Round-increment decision from rounding mode, result sign, lsb, guard and sticky.
// FP_TO_INT_RMODE_EN: honour all five modes; undefined: always round to nearest even.
module fp_round_decide
  import fpu_pkg::*;
(
  input  logic [2:0] i_rm,
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_sticky,
  output logic       o_inc
);

`ifdef FP_TO_INT_RMODE_EN
  always_comb begin
    case (i_rm)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & (i_guard | i_sticky);
      RM_RUP:  o_inc = ~i_sign & (i_guard | i_sticky);
      RM_RMM:  o_inc = i_guard;
      // RNE and the reserved codes share nearest-even
      default: o_inc = i_guard & (i_sticky | i_lsb);
    endcase
  end
`else
  logic w_unused_rm;
  assign w_unused_rm = ^{i_rm, i_sign};
  assign o_inc       = i_guard & (i_sticky | i_lsb);
`endif

endmodule

// File: rtl/fp_to_int_pipe.sv
// Pipelined float-to-integer converter (unpack / align / round+saturate) with valid/ready flow.
// Define FP_TO_INT_RMODE_EN to honour in_rm; otherwise every conversion rounds to nearest even.
module fp_to_int_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int INT_W = 32,
  localparam int FLEN  = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  in_a,
  input  logic             in_signed,
  input  logic [2:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_result,
  output logic             out_nv,
  output logic             out_nx
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int XW   = EXP_W + 2;
  localparam int SHW  = $clog2(INT_W);
  localparam int AW   = INT_W + MAN_W;

  localparam logic [INT_W-1:0] MAXS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINS = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   HALF = {2'b01, {(INT_W-1){1'b0}}};

  // flow control: a stage loads when empty or when its successor loads
  logic [3:1] r_vld;
  logic       w_en1, w_en2, w_en3;

  assign w_en3     = !r_vld[3] || out_ready;
  assign w_en2     = !r_vld[2] || w_en3;
  assign w_en1     = !r_vld[1] || w_en2;
  assign in_ready  = w_en1;
  assign out_valid = r_vld[3];

  // S1: unpack and classify
  logic                   w_sign;
  logic [EXP_W-1:0]       w_ef;
  logic [MAN_W-1:0]       w_mf;
  logic [2:0]             w_cls;
  logic signed [XW-1:0]   w_exp;
  logic [MAN_W:0]         w_sig;

  assign {w_sign, w_ef, w_mf} = in_a;
  assign w_sig = {w_ef != '0, w_mf};
  assign w_exp = (w_ef == '0) ? XW'(1 - BIAS) : $signed({2'b00, w_ef}) - XW'(BIAS);

  always_comb begin
    if (w_ef == '0)      w_cls = (w_mf == '0) ? CLS_ZERO : CLS_SUB;
    else if (&w_ef)      w_cls = (w_mf == '0) ? CLS_INF  : CLS_NAN;
    else                 w_cls = CLS_NORM;
  end

  logic                 r1_sign, r1_signed;
  logic [2:0]           r1_cls, r1_rm;
  logic signed [XW-1:0] r1_exp;
  logic [MAN_W:0]       r1_sig;

  always_ff @(posedge clk) begin
    if (w_en1 && in_valid) begin
      r1_sign   <= w_sign;
      r1_cls    <= w_cls;
      r1_exp    <= w_exp;
      r1_sig    <= w_sig;
      r1_signed <= in_signed;
      r1_rm     <= in_rm;
    end
  end

  // S2: align into integer part + guard + sticky
  logic             w_huge;
  logic [AW-1:0]    w_wide, w_shl;
  logic [INT_W-1:0] w_int;
  logic             w_g, w_s;

  assign w_huge = (r1_exp >= $signed(XW'(INT_W)));
  assign w_wide = {{(INT_W-1){1'b0}}, r1_sig};
  assign w_shl  = w_wide << r1_exp[SHW-1:0];

  always_comb begin
    w_int = '0;
    w_g   = 1'b0;
    w_s   = 1'b0;
    if (!r1_exp[XW-1]) begin
      w_int = w_shl[MAN_W +: INT_W];
      w_g   = w_shl[MAN_W-1];
      w_s   = |w_shl[MAN_W-2:0];
    end else if (r1_exp == '1) begin
      w_g   = r1_sig[MAN_W];
      w_s   = |r1_sig[MAN_W-1:0];
    end else begin
      w_s   = |r1_sig;
    end
  end

  logic             r2_sign, r2_signed, r2_nan, r2_inf, r2_huge, r2_g, r2_s;
  logic [2:0]       r2_rm;
  logic [INT_W-1:0] r2_int;

  // only magnitudes >= 2^INT_W are flagged here; the signed limit is judged on the rounded value
  always_ff @(posedge clk) begin
    if (w_en2 && r_vld[1]) begin
      r2_sign   <= r1_sign;
      r2_signed <= r1_signed;
      r2_nan    <= (r1_cls == CLS_NAN);
      r2_inf    <= (r1_cls == CLS_INF);
      r2_huge   <= w_huge;
      r2_int    <= w_int;
      r2_g      <= w_g;
      r2_s      <= w_s;
      r2_rm     <= r1_rm;
    end
  end

  // S3: round, negate, saturate, flags
  logic             w_inc;
  logic [INT_W:0]   w_magr;
  logic [INT_W-1:0] w_maxp, w_res;
  logic             w_nv, w_nx;

  fp_round_decide u_rnd (
    .i_rm     (r2_rm),
    .i_sign   (r2_sign),
    .i_lsb    (r2_int[0]),
    .i_guard  (r2_g),
    .i_sticky (r2_s),
    .o_inc    (w_inc)
  );

  assign w_magr = {1'b0, r2_int} + {{INT_W{1'b0}}, w_inc};
  assign w_maxp = r2_signed ? MAXS : '1;

  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    w_nx  = 1'b0;
    if (r2_nan) begin
      w_res = w_maxp;
      w_nv  = 1'b1;
    end else if (r2_inf || r2_huge) begin
      w_nv  = 1'b1;
      if (!r2_sign)       w_res = w_maxp;
      else if (r2_signed) w_res = MINS;
    end else if (!r2_sign) begin
      if (r2_signed ? (w_magr >= HALF) : w_magr[INT_W]) begin
        w_res = w_maxp;
        w_nv  = 1'b1;
      end else begin
        w_res = w_magr[INT_W-1:0];
        w_nx  = r2_g | r2_s;
      end
    end else if (r2_signed) begin
      if (w_magr > HALF) begin
        w_res = MINS;
        w_nv  = 1'b1;
      end else begin
        w_res = -w_magr[INT_W-1:0];
        w_nx  = r2_g | r2_s;
      end
    end else if (w_magr != '0) begin
      w_nv  = 1'b1;
    end else begin
      w_nx  = r2_g | r2_s;
    end
  end

  logic [INT_W-1:0] r3_res;
  logic             r3_nv, r3_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r3_res <= '0;
      r3_nv  <= 1'b0;
      r3_nx  <= 1'b0;
    end else begin
      if (w_en1) r_vld[1] <= in_valid;
      if (w_en2) r_vld[2] <= r_vld[1];
      if (w_en3) r_vld[3] <= r_vld[2];
      if (w_en3 && r_vld[2]) begin
        r3_res <= w_res;
        r3_nv  <= w_nv;
        r3_nx  <= w_nx;
      end
    end
  end

  assign out_result = r3_res;
  assign out_nv     = r3_nv;
  assign out_nx     = r3_nx;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Self-checking bench for fp_to_int_pipe: exact-arithmetic reference model, scoreboard, random stream.
// Tracks FP_TO_INT_RMODE_EN the same way the design does.
module tb_fp_to_int_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_a;
  logic [2:0]  in_rm;
  logic        out_valid, out_ready, out_nv, out_nx;
  logic [31:0] out_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lat_chk = 1'b0;
  bit rnd_or  = 1'b0;

  typedef struct { logic [31:0] res; logic nv; logic nx; int cyc; } exp_t;
  exp_t q[$];

  fp_to_int_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_signed(in_signed), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_nv(out_nv), .out_nx(out_nx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // exact value = sig * 2^k; the fraction is classed against one half, then the mode is applied
  function automatic logic [33:0] model(input logic [31:0] a, input logic sg, input logic [2:0] rm);
    logic         s;
    int           e, k, fr;
    logic [23:0]  sig;
    logic [199:0] mag, rem, half;
    logic [2:0]   m;
    logic         up;
    logic [31:0]  r;
    s   = a[31];
    e   = int'(a[30:23]);
    sig = {e != 0, a[22:0]};
    fr  = 0;
    if (e == 255 && a[22:0] != 0) return {1'b1, 1'b0, sg ? 32'h7FFFFFFF : 32'hFFFFFFFF};
    if (e == 255) mag = 200'd1 << 150;
    else begin
      k = (e == 0 ? 1 : e) - 150;
      if (k >= 0) mag = 200'(sig) << k;
      else if (-k > 60) begin
        mag = '0;
        fr  = (sig != 0) ? 1 : 0;
      end else begin
        mag  = 200'(sig) >> (-k);
        rem  = 200'(sig) & ((200'd1 << (-k)) - 200'd1);
        half = 200'd1 << (-k - 1);
        fr   = (rem == 0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
      end
    end
`ifdef FP_TO_INT_RMODE_EN
    m = rm;
`else
    m = 3'd0 & rm;
`endif
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && fr != 0;
      3'd3:    up = !s && fr != 0;
      3'd4:    up = fr >= 2;
      default: up = (fr == 3) || (fr == 2 && mag[0]);
    endcase
    mag = mag + 200'(up);
    if (sg) begin
      if (!s && mag > 200'h7FFFFFFF) return {1'b1, 1'b0, 32'h7FFFFFFF};
      if (s && mag > 200'h80000000)  return {1'b1, 1'b0, 32'h80000000};
      r = s ? -mag[31:0] : mag[31:0];
    end else begin
      if (!s && mag > 200'hFFFFFFFF) return {1'b1, 1'b0, 32'hFFFFFFFF};
      if (s && mag != 0)             return {1'b1, 1'b0, 32'h0};
      r = s ? 32'h0 : mag[31:0];
    end
    return {1'b0, fr != 0, r};
  endfunction

  function automatic logic [31:0] rand_a();
    int         c;
    logic [7:0] e;
    logic [22:0] m;
    c = $urandom_range(0, 15);
    m = 23'($urandom());
    case (c)
      0:       return $urandom();
      1:       e = 8'hFF;
      2:       e = 8'h00;
      3:       e = 8'($urandom_range(155, 160));
      4: begin
        e = 8'($urandom_range(125, 150));
        m = 23'($urandom_range(0, 3)) << $urandom_range(0, 22);
      end
      default: e = 8'($urandom_range(110, 162));
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // scoreboard / hold-stability monitor, sampled mid-cycle
  logic        hold_v = 1'b0;
  logic [33:0] hold_d;
  always @(negedge clk) begin
    exp_t e;
    logic [33:0] mv;
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({out_nv, out_nx, out_result}), 64'(hold_d));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %0h want none", out_result);
        end else begin
          e = q.pop_front();
          chk("result", 64'(out_result), 64'(e.res));
          chk("nv", 64'(out_nv), 64'(e.nv));
          chk("nx", 64'(out_nx), 64'(e.nx));
          if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_nv, out_nx, out_result};
      if (in_valid && in_ready) begin
        mv = model(in_a, in_signed, in_rm);
        q.push_back('{res: mv[31:0], nv: mv[33], nx: mv[32], cyc: cyc});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic s, input logic [2:0] rm);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1; in_a = a; in_signed = s; in_rm = rm;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got no in_ready want accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    logic [33:0] mv;
    int nvld;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_signed = 1'b0; in_rm = 3'd0; out_ready = 1'b1;

    // hand-computed pins on the model
    mv = model(32'h404CCCCC, 1'b1, 3'd0); chk("m_3p2", 64'(mv), 64'({2'b01, 32'd3}));
    mv = model(32'h4F000000, 1'b1, 3'd0); chk("m_2p31s", 64'(mv), 64'({2'b10, 32'h7FFFFFFF}));
    mv = model(32'hCF000000, 1'b1, 3'd0); chk("m_m2p31", 64'(mv), 64'({2'b00, 32'h80000000}));
    mv = model(32'h7FC00000, 1'b0, 3'd0); chk("m_nan_u", 64'(mv), 64'({2'b10, 32'hFFFFFFFF}));
    mv = model(32'hFF800000, 1'b1, 3'd0); chk("m_ninf", 64'(mv), 64'({2'b10, 32'h80000000}));
    mv = model(32'hBF800000, 1'b0, 3'd0); chk("m_m1_u", 64'(mv), 64'({2'b10, 32'h0}));
    mv = model(32'hBE99999A, 1'b0, 3'd1); chk("m_m0p3", 64'(mv), 64'({2'b01, 32'h0}));
    mv = model(32'hBF000000, 1'b1, 3'd0); chk("m_mhalf", 64'(mv), 64'({2'b01, 32'h0}));
    mv = model(32'h00000001, 1'b1, 3'd0); chk("m_sub", 64'(mv), 64'({2'b01, 32'h0}));
`ifdef FP_TO_INT_RMODE_EN
    mv = model(32'hBF000000, 1'b1, 3'd4); chk("m_mhalf_rmm", 64'(mv), 64'({2'b01, 32'hFFFFFFFF}));
    mv = model(32'h428C3EFA, 1'b1, 3'd3); chk("m_70_rup", 64'(mv), 64'({2'b01, 32'd71}));
    mv = model(32'h00000001, 1'b1, 3'd3); chk("m_sub_rup", 64'(mv), 64'({2'b01, 32'd1}));
`else
    mv = model(32'hBF000000, 1'b1, 3'd4); chk("m_mhalf_rmm", 64'(mv), 64'({2'b01, 32'h0}));
    mv = model(32'h428C3EFA, 1'b1, 3'd3); chk("m_70_rup", 64'(mv), 64'({2'b01, 32'd70}));
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'({out_nv, out_nx}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // back-to-back RNE stream, fixed latency
    lat_chk = 1'b1;
    send(32'h404CCCCC, 1'b1, 3'd0);
    send(32'h428C3EFA, 1'b1, 3'd0);
    send(32'h41719A9A, 1'b1, 3'd0);
    send(32'h4034B4B5, 1'b1, 3'd0);
    drain();
    lat_chk = 1'b0;

    // rounding modes, saturation, unsigned negatives, zeros, subnormals
    send(32'hBF000000, 1'b1, 3'd0);
    send(32'hBF000000, 1'b1, 3'd4);
    send(32'hBF000000, 1'b1, 3'd2);
    send(32'hBF000000, 1'b1, 3'd3);
    send(32'h428C3EFA, 1'b1, 3'd3);
    send(32'h4F000000, 1'b1, 3'd0);
    send(32'hCF000000, 1'b1, 3'd0);
    send(32'h7FC00000, 1'b0, 3'd0);
    send(32'hFF800000, 1'b1, 3'd0);
    send(32'hBF800000, 1'b0, 3'd0);
    send(32'hBE99999A, 1'b0, 3'd1);
    send(32'h80000000, 1'b1, 3'd0);
    send(32'h00000001, 1'b1, 3'd3);
    send(32'h4F7FFFFF, 1'b0, 3'd0);
    send(32'h4F800000, 1'b0, 3'd0);
    send(32'h7F800000, 1'b1, 3'd0);
    drain();

    // backpressure: three fill the pipe, the fourth waits
    out_ready = 1'b0;
    send(32'h40400000, 1'b1, 3'd0);
    send(32'h40800000, 1'b1, 3'd0);
    send(32'h40A00000, 1'b1, 3'd0);
    in_valid = 1'b1; in_a = 32'h40C00000; in_signed = 1'b1; in_rm = 3'd0;
    repeat (5) begin
      @(negedge clk); chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h40C00000, 1'b1, 3'd0);
    drain();

    // reset with three in flight
    send(32'h41000000, 1'b1, 3'd0);
    send(32'h41100000, 1'b1, 3'd0);
    send(32'h41200000, 1'b1, 3'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    nvld = 0;
    repeat (10) begin
      @(negedge clk); if (out_valid) nvld++;
    end
    chk("rst_no_stale", 64'(nvld), 64'd0);
    @(posedge clk); #1;

    // randomized stream with random gaps and backpressure
    rnd_or = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(rand_a(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    rnd_or = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
